mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It runs one transaction at a time through a request/ready/rvalid memory handshake. It returns per-requester valid pulses and stall levels; top level ORs the stalls into PC_write, IF_ID_write and the pipeline-register enables. A branch redirect (PCSrc) cancels the delivery of an in-flight fetch.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF fetch and
// MEM load/store, one transaction at a time (IDLE -> REQ -> WAIT -> RESP).
// Ports: clk/reset; if_* fetch requester (req/addr in, rdata/valid/stall
// out); d_* data requester (req/we/addr/wdata in, rdata/valid/stall out);
// flush cancels delivery of an in-flight fetch; mem_* memory handshake
// (req/we/addr/wdata out, ready/rvalid/rdata in).

module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              d_stall,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              discard_q, discard_d;
   logic [3:0]        starve_q, starve_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rsp_q, rsp_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic grant_if;
   logic fetch_ok;

   // Data has priority unless fetch has lost STARVE_MAX times in a row.
   assign grant_if = if_req && (!d_req || (starve_q == SMAX));

   // A flush in the response cycle itself also suppresses delivery.
   assign fetch_ok = !discard_q && !flush;

   assign mem_req   = (state_q == S_REQ);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   assign if_valid = (state_q == S_RESP) && !owner_q && fetch_ok;
   assign d_valid  = (state_q == S_RESP) && owner_q;
   assign if_stall = if_req && !if_valid;
   assign d_stall  = d_req && !d_valid;

   // Fetch data is held in rsp_q until RESP decides whether to deliver it,
   // so a discarded fetch never disturbs the visible if_rdata.
   assign if_rdata = if_valid ? rsp_q : if_rdata_q;
   assign d_rdata  = d_rdata_q;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      discard_d   = discard_q;
      starve_d    = starve_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_d       = rsp_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      unique case (state_q)
         S_IDLE: begin
            discard_d = 1'b0;
            if (if_req || d_req) begin
               state_d = S_REQ;
               owner_d = ~grant_if;
               if (grant_if) begin
                  mem_we_d   = 1'b0;
                  mem_addr_d = if_addr;
                  starve_d   = '0;
               end else begin
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  // Fetch only loses here while below SMAX: no overflow.
                  if (if_req) starve_d = starve_q + 4'd1;
               end
            end
         end
         S_REQ: begin
            if (flush && !owner_q) discard_d = 1'b1;
            if (mem_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flush && !owner_q) discard_d = 1'b1;
            if (mem_rvalid) begin
               state_d = S_RESP;
               if (!owner_q) rsp_d = mem_rdata;
               else if (!mem_we_q) d_rdata_d = mem_rdata;
            end
         end
         S_RESP: begin
            state_d   = S_IDLE;
            discard_d = 1'b0;
            if (!owner_q && fetch_ok) if_rdata_d = rsp_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         discard_q   <= 1'b0;
         starve_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_q       <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         discard_q   <= discard_d;
         starve_q    <= starve_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_q       <= rsp_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized bench for mem_port_arbiter
// with a transaction-level reference model and memory responder.

module tb_mem_port_arbiter;

   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_valid, if_stall;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_valid, d_stall;
   logic        flush = 1'b0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_valid(if_valid), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
      .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   int ncmp = 0;
   int nfail = 0;

   // reference model: one transaction record plus arbitration history
   int          cy, starve;
   bit          start_pending, txn_active, accepted, resp_due, flushed;
   bit          owner, we;
   logic [31:0] taddr, twdata, resp_data, if_exp, d_exp;
   bit          p_if, p_d, p_we;
   logic [31:0] p_ia, p_da, p_wd;
   int          cy_rise, req_cycles, cy_rv, cy_ifv, cy_dv, n_ifv, n_dv;
   bit          grants[$];
   // memory responder and requester knobs
   int          rv_cnt, low_cnt, rv_lat;
   bit          rdy_rand, fix_rd, rq_rand, rq_hold, fl_rand;
   logic [31:0] fix_val;
   bit          seen_ifv, seen_dv;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      starve = 0; start_pending = 0; txn_active = 0; accepted = 0;
      resp_due = 0; flushed = 0; if_exp = '0; d_exp = '0;
      rv_cnt = 0; low_cnt = 0; seen_ifv = 0; seen_dv = 0;
   endtask

   task automatic mid();
      int cls;
      bit exp_ifv, exp_dv;
      @(negedge clk);
      if (start_pending) begin
         start_pending = 0; txn_active = 1; accepted = 0; flushed = 0;
         cy_rise = cy; req_cycles = 0;
         if (p_if && (!p_d || starve == SMAX)) begin
            owner = 0; we = 0; taddr = p_ia; twdata = '0; starve = 0;
         end else begin
            owner = 1; we = p_we; taddr = p_da; twdata = p_wd;
            if (p_if) starve = (starve < SMAX) ? starve + 1 : SMAX;
         end
         grants.push_back(owner);
      end
      cls = resp_due ? 3 : (txn_active ? (accepted ? 2 : 1) : 0);
      exp_ifv = (cls == 3) && !owner && !flushed && !flush;
      exp_dv  = (cls == 3) && owner;
      chk("mem_req", mem_req, cls == 1);
      if (cls == 1) begin
         req_cycles++;
         chk("mem_addr", mem_addr, taddr);
         chk("mem_we", mem_we, we);
         if (we) chk("mem_wdata", mem_wdata, twdata);
      end
      chk("if_valid", if_valid, exp_ifv);
      chk("d_valid", d_valid, exp_dv);
      chk("if_rdata", if_rdata, exp_ifv ? resp_data : if_exp);
      chk("d_rdata", d_rdata, (exp_dv && !we) ? resp_data : d_exp);
      chk("if_stall", if_stall, if_req && !exp_ifv);
      chk("d_stall", d_stall, d_req && !exp_dv);
      seen_ifv = exp_ifv;
      seen_dv = exp_dv;
      if (cls == 1) begin
         if (flush && !owner) flushed = 1;
         if (mem_ready) accepted = 1;
      end else if (cls == 2) begin
         if (flush && !owner) flushed = 1;
         if (mem_rvalid) begin
            resp_due = 1; resp_data = mem_rdata; cy_rv = cy;
         end
      end else if (cls == 3) begin
         if (exp_ifv) begin
            if_exp = resp_data; cy_ifv = cy; n_ifv++;
         end
         if (exp_dv) begin
            if (!we) d_exp = resp_data;
            cy_dv = cy; n_dv++;
         end
         resp_due = 0; txn_active = 0;
      end else if (if_req || d_req) begin
         start_pending = 1;
         p_if = if_req; p_d = d_req; p_we = d_we;
         p_ia = if_addr; p_da = d_addr; p_wd = d_wdata;
      end
      if (mem_req && mem_ready)
         rv_cnt = (rv_lat == 0) ? int'($urandom_range(1, 3)) : rv_lat;
      if (mem_req && !mem_ready && low_cnt > 0) low_cnt--;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cy++;
      mem_rvalid = (rv_cnt == 1);
      mem_rdata = (rv_cnt == 1 && fix_rd) ? fix_val : $urandom;
      if (rv_cnt > 0) rv_cnt--;
      mem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : (low_cnt == 0);
   endtask

   task automatic cyc();
      logic        nif, nd, nwe, nfl;
      logic [31:0] nia, nda, nwd;
      mid();
      nif = if_req; nia = if_addr; nd = d_req; nwe = d_we;
      nda = d_addr; nwd = d_wdata; nfl = flush;
      if (rq_rand) begin
         if (seen_ifv || !if_req) begin
            nif = ($urandom_range(0, 9) < 5);
            nia = $urandom & 32'h0000_FFFC;
         end
         if (seen_dv || !d_req) begin
            nd = ($urandom_range(0, 9) < 4);
            nwe = 1'($urandom_range(0, 1));
            nda = $urandom & 32'h0000_FFFC;
            nwd = $urandom;
         end
      end else if (rq_hold) begin
         if (seen_ifv) nia = if_addr + 32'd4;
         if (seen_dv) nda = d_addr + 32'd4;
      end else begin
         if (seen_ifv) nif = 1'b0;
         if (seen_dv) nd = 1'b0;
      end
      if (fl_rand) nfl = ($urandom_range(0, 9) == 0);
      adv();
      if_req = nif; if_addr = nia; d_req = nd; d_we = nwe;
      d_addr = nda; d_wdata = nwd; flush = nfl;
   endtask

   task automatic ncyc(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int          n0, n1;
      logic [31:0] old;
      bit          gexp [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      model_reset();
      cy = 0; n_ifv = 0; n_dv = 0; cy_ifv = -1; cy_dv = -1; cy_rv = -1;
      rv_lat = 1; rdy_rand = 0; fix_rd = 1; fix_val = 32'h0050_0093;
      rq_rand = 0; rq_hold = 0; fl_rand = 0;

      // asynchronous reset before any clock edge
      #1 reset = 1'b1;
      #3;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_if_valid", if_valid, 1'b0);
      chk("rst_d_valid", d_valid, 1'b0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      mem_ready = 1'b1;
      ncyc(2);

      // fetch only, minimum latency
      n0 = cy;
      if_req = 1'b1; if_addr = 32'h40;
      ncyc(6);
      chk("fetch_req_cycle", cy_rise, n0 + 1);
      chk("fetch_req_len", req_cycles, 1);
      chk("fetch_valid_cycle", cy_ifv, n0 + 3);
      chk("fetch_rdata", if_rdata, 32'h0050_0093);

      // store with three cycles of backpressure
      n1 = n_dv;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
      low_cnt = 3;
      ncyc(9);
      chk("store_req_len", req_cycles, 4);
      chk("store_dvalid_cnt", n_dv, n1 + 1);
      chk("store_dvalid_cycle", cy_dv, cy_rv + 1);
      chk("store_d_rdata", d_rdata, 32'h0);

      // contention with both requesters held
      grants.delete();
      rq_hold = 1;
      if_req = 1'b1; if_addr = 32'h1000;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
      for (int i = 0; i < 200 && grants.size() < 10; i++) cyc();
      chk("starve_grants", grants.size() >= 10, 1'b1);
      for (int i = 0; i < 10 && i < grants.size(); i++)
         chk($sformatf("starve_grant%0d", i), grants[i], gexp[i]);
      rq_hold = 0;
      ncyc(20);

      // flush while the fetch waits for its response
      old = if_exp;
      n1 = n_ifv;
      rv_lat = 2; fix_val = 32'hCAFE_0001;
      n0 = cy;
      if_req = 1'b1; if_addr = 32'h80;
      ncyc(2);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();
      if_req = 1'b0;
      ncyc(4);
      chk("flushw_rvalid_cycle", cy_rv, n0 + 3);
      chk("flushw_no_valid", n_ifv, n1);
      chk("flushw_if_rdata", if_rdata, old);
      chk("flushw_idle", mem_req, 1'b0);

      // flush has no effect on a data load
      n1 = n_dv;
      fix_val = 32'h1234_5678;
      n0 = cy;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      ncyc(2);
      flush = 1'b1;
      ncyc(3);
      flush = 1'b0;
      ncyc(3);
      chk("flushd_dvalid_cnt", n_dv, n1 + 1);
      chk("flushd_dvalid_cycle", cy_dv, n0 + 4);
      chk("flushd_d_rdata", d_rdata, 32'h1234_5678);

      // reset in the middle of a fetch
      rv_lat = 3;
      if_req = 1'b1; if_addr = 32'h44;
      ncyc(2);
      reset = 1'b1;
      #1;
      chk("mrst_mem_req", mem_req, 1'b0);
      chk("mrst_mem_addr", mem_addr, 32'h0);
      chk("mrst_if_valid", if_valid, 1'b0);
      chk("mrst_d_valid", d_valid, 1'b0);
      chk("mrst_if_rdata", if_rdata, 32'h0);
      chk("mrst_d_rdata", d_rdata, 32'h0);
      if_req = 1'b0; mem_rvalid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      rv_lat = 1; fix_val = 32'h0000_0013;
      n0 = cy;
      if_req = 1'b1; if_addr = 32'h48;
      ncyc(6);
      chk("mrst_req_cycle", cy_rise, n0 + 1);
      chk("mrst_valid_cycle", cy_ifv, n0 + 3);
      chk("mrst_if_rdata", if_rdata, 32'h0000_0013);

      // randomized traffic, backpressure, latency and flushes
      n0 = n_ifv; n1 = n_dv;
      rq_rand = 1; rdy_rand = 1; rv_lat = 0; fl_rand = 1; fix_rd = 0;
      ncyc(3000);
      chk("rand_progress", (n_ifv - n0 > 20) && (n_dv - n1 > 20), 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
